// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops, plus an iterative
// one-bit-per-cycle shifter for SRA/SRL/SLL/ROR, with a start/busy/done handshake.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [2:0]                 op,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic [$clog2(WIDTH)-1:0]   shamt,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           result,
  output logic                       ovf
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_SRA = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;
  localparam logic [2:0] OP_OR  = 3'b111;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, stateNext;
  logic [2:0]       opLat, opLatNext;
  logic [SHW-1:0]   count, countNext;
  logic [WIDTH-1:0] resultNext;
  logic             ovfNext, doneNext;

  logic signed [WIDTH-1:0] aS, bS, sumS, diffS;

  function automatic logic isShift(input logic [2:0] o);
    return (o == OP_SRA) || (o == OP_SRL) || (o == OP_SLL) || (o == OP_ROR);
  endfunction

  function automatic logic [WIDTH-1:0] shiftStep(input logic [2:0] o,
                                                 input logic [WIDTH-1:0] v);
    case (o)
      OP_SRA:  return {v[WIDTH-1], v[WIDTH-1:1]};
      OP_SRL:  return {1'b0, v[WIDTH-1:1]};
      OP_SLL:  return {v[WIDTH-2:0], 1'b0};
      OP_ROR:  return {v[0], v[WIDTH-1:1]};
      default: return v;
    endcase
  endfunction

  // Overflow when the true result sign cannot be represented: the effective
  // operand signs agree yet the wrapped result sign differs from a's.
  function automatic logic addSubOvf(input logic isSub,
                                     input logic signed [WIDTH-1:0] x,
                                     input logic signed [WIDTH-1:0] y,
                                     input logic signed [WIDTH-1:0] s);
    logic signsMatch;
    signsMatch = isSub ? (x[WIDTH-1] != y[WIDTH-1]) : (x[WIDTH-1] == y[WIDTH-1]);
    return signsMatch && (s[WIDTH-1] != x[WIDTH-1]);
  endfunction

  assign aS    = $signed(a);
  assign bS    = $signed(b);
  assign sumS  = aS + bS;
  assign diffS = aS - bS;
  assign busy  = (state == SHIFT);

  always_comb begin
    stateNext  = state;
    opLatNext  = opLat;
    countNext  = count;
    resultNext = result;
    ovfNext    = ovf;
    doneNext   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          opLatNext = op;
          ovfNext   = 1'b0;
          if (isShift(op) && (shamt != '0)) begin
            resultNext = a;
            countNext  = shamt;
            stateNext  = SHIFT;
          end else begin
            countNext = '0;
            doneNext  = 1'b1;
            case (op)
              OP_ADD: begin
                resultNext = sumS;
                ovfNext    = addSubOvf(1'b0, aS, bS, sumS);
              end
              OP_SUB: begin
                resultNext = diffS;
                ovfNext    = addSubOvf(1'b1, aS, bS, diffS);
              end
              OP_AND:  resultNext = a & b;
              OP_OR:   resultNext = a | b;
              default: resultNext = a;
            endcase
          end
        end
      end
      SHIFT: begin
        resultNext = shiftStep(opLat, result);
        countNext  = count - 1'b1;
        if (count == SHW'(1)) begin
          stateNext = IDLE;
          doneNext  = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      opLat  <= '0;
      count  <= '0;
      result <= '0;
      ovf    <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= stateNext;
      opLat  <= opLatNext;
      count  <= countNext;
      result <= resultNext;
      ovf    <= ovfNext;
      done   <= doneNext;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: fixed vector table, hand-written handshake/reset sequences,
// and random ops compared against an arithmetic reference model.
module tb_seq_alu;

  localparam int W = 8;

  logic         clk, reset, start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic [2:0]   shamt;
  logic         busy, done, ovf;
  logic [W-1:0] result;

  int total = 0;
  int bad   = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .shamt(shamt), .busy(busy), .done(done), .result(result), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   o;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [2:0]   sh;
    logic [W-1:0] r;
    logic         ov;
    int           lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic over whole shift amounts.
  function automatic void model(input logic [2:0] o, input logic [W-1:0] x,
                                input logic [W-1:0] y, input logic [2:0] n,
                                output logic [W-1:0] r, output logic ov,
                                output int lat);
    int sx, sy, s;
    sx = $signed(x);
    sy = $signed(y);
    ov = 1'b0;
    lat = 1;
    r = x;
    case (o)
      3'd0: begin s = sx >>> n; r = W'(s); lat = n + 1; end
      3'd1: begin r = x >> n; lat = n + 1; end
      3'd2: begin s = sx - sy; r = W'(s); ov = (s > 127) || (s < -128); end
      3'd3: begin s = sx + sy; r = W'(s); ov = (s > 127) || (s < -128); end
      3'd4: begin r = x << n; lat = n + 1; end
      3'd5: begin r = (x >> n) | (x << (W - n)); lat = n + 1; end
      3'd6: r = x & y;
      default: r = x | y;
    endcase
  endfunction

  // Called at a negedge; drives a request into the current cycle, returns at
  // the negedge of the done cycle so a following call starts back-to-back.
  task automatic runOp(input logic [2:0] o, input logic [W-1:0] ia,
                       input logic [W-1:0] ib, input logic [2:0] sh,
                       input logic [W-1:0] eRes, input logic eOvf,
                       input int eLat, input string nm);
    int lat, busyCnt;
    lat = 0;
    busyCnt = 0;
    op = o; a = ia; b = ib; shamt = sh; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); op = 3'($urandom); shamt = 3'($urandom);
    for (int k = 1; k <= W + 2; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busyCnt++;
    end
    chk({nm, " latency"}, lat, eLat);
    chk({nm, " busy cycles"}, busyCnt, eLat - 1);
    chk({nm, " busy at done"}, busy, 0);
    chk({nm, " result"}, result, eRes);
    chk({nm, " ovf"}, ovf, eOvf);
  endtask

  initial begin
    logic [W-1:0] mr;
    logic         mo;
    int           ml, nDone, doneAt;
    logic [W-1:0] seenRes;

    vecs[0]  = '{3'd3, 8'h7F, 8'h01, 3'd0, 8'h80, 1'b1, 1};
    vecs[1]  = '{3'd2, 8'h05, 8'h07, 3'd0, 8'hFE, 1'b0, 1};
    vecs[2]  = '{3'd0, 8'h90, 8'h00, 3'd3, 8'hF2, 1'b0, 4};
    vecs[3]  = '{3'd1, 8'h90, 8'h00, 3'd3, 8'h12, 1'b0, 4};
    vecs[4]  = '{3'd5, 8'h81, 8'h00, 3'd1, 8'hC0, 1'b0, 2};
    vecs[5]  = '{3'd4, 8'h81, 8'h00, 3'd7, 8'h80, 1'b0, 8};
    vecs[6]  = '{3'd4, 8'h5A, 8'h00, 3'd0, 8'h5A, 1'b0, 1};
    vecs[7]  = '{3'd2, 8'h80, 8'h01, 3'd0, 8'h7F, 1'b1, 1};
    vecs[8]  = '{3'd6, 8'hF0, 8'h3C, 3'd0, 8'h30, 1'b0, 1};
    vecs[9]  = '{3'd7, 8'hF0, 8'h0F, 3'd0, 8'hFF, 1'b0, 1};
    vecs[10] = '{3'd5, 8'h01, 8'h00, 3'd7, 8'h02, 1'b0, 8};
    vecs[11] = '{3'd3, 8'h80, 8'h80, 3'd0, 8'h00, 1'b1, 1};
    vecs[12] = '{3'd0, 8'h7F, 8'h00, 3'd7, 8'h00, 1'b0, 8};

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; shamt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle after reset", {busy, done, ovf, result}, 0);
    end

    // Table vectors, all issued back-to-back.
    for (int i = 0; i < 13; i++)
      runOp(vecs[i].o, vecs[i].va, vecs[i].vb, vecs[i].sh,
            vecs[i].r, vecs[i].ov, vecs[i].lat, $sformatf("vec%0d", i));

    // Start during SHIFT is ignored.
    @(negedge clk);
    op = 3'd0; a = 8'h80; shamt = 3'd5; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    nDone = 0; doneAt = 0; seenRes = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin nDone++; doneAt = k; seenRes = result; end
      if (k == 2) begin op = 3'd3; a = 8'h01; b = 8'h01; start = 1'b1; end
    end
    chk("ignored start done count", nDone, 1);
    chk("ignored start done cycle", doneAt, 6);
    chk("ignored start result", seenRes, 8'hFC);

    // Accept in the done cycle of a shift.
    runOp(3'd1, 8'hC4, 8'h00, 3'd2, 8'h31, 1'b0, 3, "srl before b2b");
    runOp(3'd6, 8'hAA, 8'h0F, 3'd0, 8'h0A, 1'b0, 1, "and in done cycle");

    // Reset in the 2nd busy cycle of SLL shamt=6.
    @(negedge clk);
    op = 3'd4; a = 8'hFF; shamt = 3'd6; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async reset outputs", {busy, done, ovf, result}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    nDone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done || busy || result != 0) nDone++;
    end
    chk("no done after reset abort", nDone, 0);

    // Reset coinciding with start drops the op.
    @(negedge clk);
    op = 3'd3; a = 8'h11; b = 8'h22; start = 1'b1; reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("reset beats start", {busy, done, ovf, result}, 0);

    // Random ops against the model, issued back-to-back.
    for (int i = 0; i < 150; i++) begin
      logic [2:0]   ro, rs;
      logic [W-1:0] ra, rb;
      ro = 3'($urandom); rs = 3'($urandom);
      ra = W'($urandom); rb = W'($urandom);
      model(ro, ra, rb, rs, mr, mo, ml);
      runOp(ro, ra, rb, rs, mr, mo, ml, $sformatf("rand%0d op%0d", i, ro));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised multi-cycle ALU that replaces the fixed 4-bit combinational ALU in the datapath. It accepts one operation per start pulse and latches its operands. Arithmetic and logic ops finish in one cycle. Shift and rotate ops use an iterative one-bit-per-cycle shifter, so their latency scales with the shift amount. Results, a signed-overflow flag and a one-cycle `done` pulse are returned to the controlling FSM over a start/busy/done handshake.

## Interface
- `WIDTH`, default 8: operand and result width. Must be a power of two, ≥ 4.
- `SHW` (localparam) = $clog2(WIDTH): shift-amount width.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  request; sampled only when idle (`busy`=0).
- `op`  in  3  000 SRA, 001 SRL, 010 SUB (a−b), 011 ADD, 100 SLL, 101 ROR, 110 AND, 111 OR.
- `a`  in  WIDTH  operand A / shift source.
- `b`  in  WIDTH  operand B (ignored for shifts).
- `shamt`  in  SHW  shift/rotate amount (ignored for non-shift ops).
- `busy`  out  1  high while the shifter is iterating.
- `done`  out  1  one-cycle pulse; `result`/`ovf` valid in that cycle.
- `result`  out  WIDTH  registered result; held until the next accept.
- `ovf`  out  1  signed overflow of ADD/SUB; 0 for all other ops.

## Operation
- States: IDLE, SHIFT. `busy` = (state == SHIFT).
- Accept: state is IDLE and `start`=1 at a rising edge. At that edge `op` and `shamt` are latched.
- Non-shift op, or shift op with `shamt`=0, at the accept edge:
  - `result` ← f(a,b) (shift ops with `shamt`=0 give `result` ← a).
  - `ovf` updated; `done` ← 1; state stays IDLE.
- Shift op with `shamt`=n>0, at the accept edge:
  - `result` ← a; count ← n; `ovf` ← 0; state ← SHIFT.
- Each edge in SHIFT: `result` ← one-bit step of the latched op; count ← count−1. When count==1 at that edge: state ← IDLE, `done` ← 1.
- One-bit steps:
  - SRA: MSB replicated.
  - SRL: 0 in at MSB.
  - SLL: 0 in at LSB.
  - ROR: LSB moves to MSB.
- ADD/SUB: modulo 2^WIDTH. `ovf` = operands' sign bits agree (ADD) or differ (SUB) and the result sign differs from a's sign.
- AND/OR: bitwise.
- `done` is otherwise 0. It never coincides with `busy`=1.
- `start` while `busy`=1 is ignored; no queueing.
- `start` in the `done` cycle is a legal accept (back-to-back).
- `a`, `b` and `op` may change freely after accept without affecting the operation in progress.
- `result` during SHIFT shows intermediate values. It is only defined valid in the `done` cycle and while idle afterwards.

## Timing
- Reset values: state IDLE, count 0, `busy` 0, `done` 0, `result` 0, `ovf` 0.
- Latency: accept in cycle c gives `done` in cycle c+1+n, with n = `shamt` for SRA/SRL/SLL/ROR and n = 0 otherwise. Maximum latency is WIDTH cycles.
- `busy` is high for exactly n cycles, c+1 … c+n.
- Throughput: one op per 1+n cycles with back-to-back starts.
- Reset asserted mid-SHIFT: abort immediately to reset values. No `done` is produced for the aborted op.
- Reset asserted in the same cycle as `start`: reset wins and the op is dropped.

## Test plan
- Reset, then idle 5 cycles → `busy`=0, `done`=0, `result`=0x00, `ovf`=0 throughout.
- ADD a=0x7F b=0x01, then SUB a=0x05 b=0x07 back-to-back → `done` pulses in c+1 and c+2 with `result`=0x80/`ovf`=1, then `result`=0xFE/`ovf`=0.
- SRA a=0x90 `shamt`=3 → `busy` high 3 cycles, `done` in c+4 with `result`=0xF2. Repeat with SRL → 0x12.
- ROR a=0x81 `shamt`=1 → `result`=0xC0 in c+2. SLL a=0x81 `shamt`=7 → `result`=0x80 in c+8. SLL `shamt`=0 → `result`=a in c+1, `busy` never high.
- During SRA `shamt`=5: pulse `start` with ADD in the 2nd busy cycle → ignored, single `done` with the SRA result. Then `start` held high in the `done` cycle → new op accepted.
- Assert `reset` in the 2nd busy cycle of SLL `shamt`=6 → outputs return to reset values immediately; no `done` appears over the following 8 cycles.
